// File: rtl/game_sequencer_pkg.sv
// Shared snake-game types, step timing and screen constants.
// Compile this file ahead of the other design files so the `GAME_TICK and `MAX_LENGTH macros are visible.
`ifndef GAME_SEQUENCER_PKG_SV
`define GAME_SEQUENCER_PKG_SV

`define GAME_TICK 2500000
`define MAX_LENGTH 64

package game_sequencer_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int CELL_PX  = 16;

    typedef enum logic [1:0] {
        initial_state = 2'd0,
        game_state    = 2'd1,
        lose_state    = 2'd2
    } state_t;

    // Opposite headings differ only in bit 0.
    typedef enum logic [1:0] {
        dir_up    = 2'd0,
        dir_down  = 2'd1,
        dir_left  = 2'd2,
        dir_right = 2'd3
    } direction_t;

    function automatic direction_t opposite(input direction_t d);
        return direction_t'(d ^ 2'b01);
    endfunction

endpackage

`endif

// File: rtl/game_sequencer_rise_detect.sv
// Rising-edge detector for synchronised button levels; history resets high so a
// button held through reset does not produce a pulse.
module rise_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic in,
    output logic pulse
);

    logic prev_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= in;
        end
    end

    assign pulse = in & ~prev_reg;

endmodule

// File: rtl/game_sequencer.sv
// Snake game phase sequencer: start/lose FSM, step timer, turn buffering and score.
// Define HIGH_SCORE_EN to keep a best-score register; otherwise high_score is tied to 0.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int TICK    = `GAME_TICK,
    parameter int SCORE_W = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     btn_start,
    input  logic [3:0]               btn_dir,
    input  logic                     lose_logic,
    input  logic                     food_eaten,
    output state_t                   state,
    output direction_t               direction,
    output logic [$clog2(TICK)-1:0]  ms_count,
    output logic [SCORE_W-1:0]       score,
    output logic [SCORE_W-1:0]       high_score
);

    localparam int MS_W = $clog2(TICK);
    localparam logic [MS_W-1:0] MS_ONE  = MS_W'(1);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(TICK - 1);

    state_t              state_reg, state_next;
    direction_t          dir_reg, dir_next;
    direction_t          pend_reg, pend_next;
    logic [MS_W-1:0]     ms_reg, ms_next;
    logic [SCORE_W-1:0]  score_reg, score_next, score_inc;
    logic                start_pulse;
    logic                req_valid;
    direction_t          req_dir;

    rise_detect u_start_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (btn_start),
        .pulse   (start_pulse)
    );

    assign score_inc = (score_reg == {SCORE_W{1'b1}}) ? score_reg : score_reg + 1'b1;

    always_comb begin
        req_valid = |btn_dir;
        req_dir   = dir_right;
        if (btn_dir[3]) begin
            req_dir = dir_up;
        end else if (btn_dir[2]) begin
            req_dir = dir_down;
        end else if (btn_dir[1]) begin
            req_dir = dir_left;
        end
    end

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        pend_next  = pend_reg;
        ms_next    = ms_reg;
        score_next = score_reg;
        unique case (state_reg)
            initial_state: begin
                if (start_pulse) begin
                    state_next = game_state;
                    dir_next   = dir_right;
                    pend_next  = dir_right;
                    ms_next    = MS_ONE;
                    score_next = '0;
                end
            end
            game_state: begin
                if (req_valid && (req_dir != opposite(dir_reg))) begin
                    pend_next = req_dir;
                end
                // Committing the freshly filtered request keeps pending never opposite to direction.
                if (ms_reg == MS_LAST) begin
                    dir_next = pend_next;
                    ms_next  = '0;
                end else begin
                    ms_next = ms_reg + 1'b1;
                end
                if (food_eaten) begin
                    score_next = score_inc;
                end
                if (lose_logic) begin
                    state_next = lose_state;
                    ms_next    = MS_ONE;
                end
            end
            lose_state: begin
                if (start_pulse) begin
                    state_next = initial_state;
                end
            end
            default: begin
                state_next = initial_state;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= initial_state;
            dir_reg   <= dir_right;
            pend_reg  <= dir_right;
            ms_reg    <= MS_ONE;
            score_reg <= '0;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
            pend_reg  <= pend_next;
            ms_reg    <= ms_next;
            score_reg <= score_next;
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_reg;

    // score_next already carries any same-cycle food increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            high_reg <= '0;
        end else if ((state_reg == game_state) && lose_logic && (score_next > high_reg)) begin
            high_reg <= score_next;
        end
    end

    assign high_score = high_reg;
`else
    assign high_score = '0;
`endif

    assign state     = state_reg;
    assign direction = dir_reg;
    assign ms_count  = ms_reg;
    assign score     = score_reg;

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL take parameter TICK, default `tick, clock cycles per snake step (must be at least 2).
REQ-002 The block SHALL take parameter SCORE_W, default 16, score counter width.
REQ-003 The block SHALL have port clock, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port btn_start, input, 1 bit, level-sensitive start button, already synchronised.
REQ-006 The block SHALL have port btn_dir, input, 4 bits, levels ordered {up, down, left, right}, already synchronised.
REQ-007 The block SHALL have port lose_logic, input, 1 bit, collision flag from the snake datapath.
REQ-008 The block SHALL have port food_eaten, input, 1 bit, one-cycle food pulse from the snake datapath.
REQ-009 The block SHALL have port state, output, state_t, game phase.
REQ-010 The block SHALL have port direction, output, direction_t, committed heading.
REQ-011 The block SHALL have port ms_count, output, $clog2(TICK) bits, step phase; the snake moves when it is 0.
REQ-012 The block SHALL have port score, output, SCORE_W bits, current score.
REQ-013 The block SHALL have port high_score, output, SCORE_W bits, best score since reset.

Function
REQ-014 The state machine SHALL have states initial_state, game_state and lose_state.
REQ-015 Transitions SHALL be: initial->game on a btn_start rising edge; game->lose when lose_logic=1; lose->initial on a btn_start rising edge; all other cases hold.
REQ-016 A btn_start rising edge SHALL be btn_start=1 with the previous-cycle sample 0; holding the button SHALL not retrigger.
REQ-017 btn_start SHALL be ignored while in game_state.
REQ-018 ms_count SHALL load 1 on entry to game_state, then increment each cycle, wrapping TICK-1 to 0.
REQ-019 ms_count SHALL hold at 1 in initial_state and lose_state, so no step is ever issued outside game_state.
REQ-020 The pending direction SHALL be updated from btn_dir, priority up>down>left>right, only in game_state.
REQ-021 A request opposite to the committed direction SHALL be discarded, so no reversal is possible.
REQ-022 direction SHALL take the pending value in the cycle where ms_count==TICK-1, giving at most one turn per step and a valid heading when ms_count==0.
REQ-023 On the initial->game transition, direction and pending SHALL both be set to right.
REQ-024 score SHALL clear on the initial->game transition.
REQ-025 score SHALL increment by 1 for every food_eaten pulse sampled while state==game_state, saturating at all-ones.
REQ-026 If lose_logic and food_eaten are asserted in the same cycle, the increment SHALL still apply and the transition to lose_state SHALL occur in that same cycle.
REQ-027 score SHALL hold its value in lose_state and initial_state.

Reset
REQ-028 Reset SHALL set state=initial_state, direction=right, pending=right, ms_count=1, score=0, high_score=0 and the start-edge history=1, so a button held through reset does not start a game.
REQ-029 Reset asserted mid-game SHALL abort immediately to these values, independent of the clock.

Configuration
REQ-030 With HIGH_SCORE_EN defined, high_score SHALL load max(high_score, final score) on the game->lose transition, using the final score including any same-cycle increment.
REQ-031 Without HIGH_SCORE_EN, high_score SHALL be constant 0 and no high-score register SHALL be synthesised.

Structure
REQ-032 state_t (including lose_state), direction_t and the `tick, `max_length and screen constants SHALL live in the shared config.svh package.
REQ-033 Start-edge detection SHALL be the sub-module rise_detect (clock, reset_n, in, pulse), reusable for the other buttons.

Verification
REQ-034 Bench: TICK=4; reset with btn_start held high -> state stays initial_state and ms_count=1.
REQ-035 Bench: release then press start -> state=game_state next cycle; ms_count sequence 1,2,3,0,1; direction=right.
REQ-036 Bench: direction=right, press left, then up within one step -> left discarded; direction=up takes effect at ms_count 3->0.
REQ-037 Bench: 3 food_eaten pulses in game_state -> score=3; with SCORE_W=2 and 5 pulses -> score=3 (saturated).
REQ-038 Bench: lose_logic and food_eaten asserted together at score 4 -> state=lose_state, score=5, high_score=5 (HIGH_SCORE_EN defined) or 0 (undefined).
REQ-039 Bench: reset_n pulsed low mid-game at score 7 -> all outputs return to their reset values asynchronously; high_score=0.
